// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared KNN pipeline types and default widths
package knn_pkg;

  // Default widths shared with the distance calculator.
  localparam int KNN_W      = 16;
  localparam int KNN_TYPE_W = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VOTE    = 2'd1,
    OUTPUT  = 2'd2
  } knn_state_t;

  // One slot of the sorted neighbour list.
  typedef struct packed {
    logic                  valid;
    logic [KNN_W-1:0]      distance;
    logic [KNN_TYPE_W-1:0] type_id;
  } knn_entry_t;

endpackage

// File: rtl/knn_insert_list.sv
// rtl/knn_insert_list.sv - sorted K_MAX-deep list with single-cycle stable insertion
module knn_insert_list #(
  parameter int W      = 16,
  parameter int TYPE_W = 3,
  parameter int K_MAX  = 8
) (
  input  logic                         clk,
  input  logic                         insert,
  input  logic                         clear,
  input  logic [W-1:0]                 distance,
  input  logic [TYPE_W-1:0]            type_id,
  output logic [K_MAX*TYPE_W-1:0]      entry_type,
  output logic [W-1:0]                 head_distance,
  output logic [$clog2(K_MAX+1)-1:0]   count
);

  localparam int CW = $clog2(K_MAX+1);

  logic [W-1:0]      dist_q [K_MAX];
  logic [TYPE_W-1:0] type_q [K_MAX];
  logic [CW-1:0]     count_q;
  logic [K_MAX-1:0]  le;

  // le[i]: slot i is occupied and sorts at or before the new beat. Because the
  // list is sorted this is a prefix mask, so its edge is the insertion point and
  // equal distances land after existing ones.
  always_comb begin
    le = '0;
    for (int i = 0; i < K_MAX; i++) begin
      le[i] = (CW'(i) < count_q) && (dist_q[i] <= distance);
    end
  end

  // Insert at the mask edge and shift the tail down; the last slot falls off.
  // When every slot is occupied and <= the beat, the beat is dropped.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
      for (int i = 0; i < K_MAX; i++) begin
        dist_q[i] <= '1;
        type_q[i] <= '0;
      end
    end else if (insert && !le[K_MAX-1]) begin
      if (!le[0]) begin
        dist_q[0] <= distance;
        type_q[0] <= type_id;
      end
      for (int i = 1; i < K_MAX; i++) begin
        if (!le[i]) begin
          if (le[i-1]) begin
            dist_q[i] <= distance;
            type_q[i] <= type_id;
          end else begin
            dist_q[i] <= dist_q[i-1];
            type_q[i] <= type_q[i-1];
          end
        end
      end
      if (count_q != CW'(K_MAX)) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  // Flatten the label column for the voter's rank mux.
  always_comb begin
    entry_type = '0;
    for (int i = 0; i < K_MAX; i++) begin
      entry_type[i*TYPE_W +: TYPE_W] = type_q[i];
    end
  end

  assign head_distance = dist_q[0];
  assign count         = count_q;

endmodule

// File: rtl/knn_topk_voter.sv
// rtl/knn_topk_voter.sv - streaming top-K selector with majority vote per frame
module knn_topk_voter
  import knn_pkg::*;
#(
  parameter int W      = KNN_W,
  parameter int TYPE_W = KNN_TYPE_W,
  parameter int K_MAX  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(K_MAX+1)-1:0]   k_sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_distance,
  input  logic [TYPE_W-1:0]            in_type,
  input  logic                         in_last,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [TYPE_W-1:0]            inferred_type,
  output logic [W-1:0]                 result_min_distance,
  output logic [$clog2(K_MAX+1)-1:0]   result_k,
  output logic [CNT_W-1:0]             result_samples
);

  localparam int KW = $clog2(K_MAX+1);
  localparam int NT = 2**TYPE_W;

  knn_state_t          state;
  logic [KW-1:0]       k_lat, k_eff, rank;
  logic [KW-1:0]       votes [NT];
  logic [TYPE_W-1:0]   best;
  logic [KW-1:0]       best_count;
  logic [CNT_W-1:0]    samples;

  logic [K_MAX*TYPE_W-1:0] entry_type;
  logic [W-1:0]            head_distance;
  logic [KW-1:0]           list_count;

  logic                accept, handshake;
  logic [KW-1:0]       k_clamped, k_frame, count_after, k_last;
  logic [TYPE_W-1:0]   vote_type, best_next;
  logic [KW-1:0]       vote_count;
  logic                vote_wins;

  assign in_ready  = (state == COLLECT) && !rst;
  assign accept    = in_valid && in_ready;
  assign handshake = result_valid && result_ready;

  knn_insert_list #(.W(W), .TYPE_W(TYPE_W), .K_MAX(K_MAX)) u_list (
    .clk           (clk),
    .insert        (accept),
    .clear         (rst || handshake),
    .distance      (in_distance),
    .type_id       (in_type),
    .entry_type    (entry_type),
    .head_distance (head_distance),
    .count         (list_count)
  );

  // K clamp, effective K for the closing beat, and the per-rank vote update.
  always_comb begin
    k_clamped = k_sel;
    if (k_sel == '0) begin
      k_clamped = KW'(1);
    end else if (k_sel > KW'(K_MAX)) begin
      k_clamped = KW'(K_MAX);
    end
    // An empty list means this beat opens the frame, so k_sel is live now.
    k_frame     = (list_count == '0) ? k_clamped : k_lat;
    count_after = (list_count == KW'(K_MAX)) ? list_count : list_count + KW'(1);
    k_last      = (k_frame < count_after) ? k_frame : count_after;
    vote_type   = entry_type[rank*TYPE_W +: TYPE_W];
    vote_count  = votes[vote_type] + KW'(1);
    // Strictly greater keeps the label that reached the count first.
    vote_wins   = vote_count > best_count;
    best_next   = vote_wins ? vote_type : best;
  end

  // Frame FSM: collect beats, vote one rank per cycle, then hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= COLLECT;
      k_lat               <= '0;
      k_eff               <= '0;
      rank                <= '0;
      best                <= '0;
      best_count          <= '0;
      samples             <= '0;
      result_valid        <= 1'b0;
      inferred_type       <= '0;
      result_min_distance <= '1;
      result_k            <= '0;
      result_samples      <= '0;
      for (int i = 0; i < NT; i++) votes[i] <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (list_count == '0) k_lat <= k_clamped;
            if (samples != '1) samples <= samples + CNT_W'(1);
            if (in_last) begin
              k_eff <= k_last;
              rank  <= '0;
              state <= VOTE;
            end
          end
        end
        VOTE: begin
          votes[vote_type] <= vote_count;
          if (vote_wins) begin
            best       <= vote_type;
            best_count <= vote_count;
          end
          rank <= rank + KW'(1);
          if (rank == k_eff - KW'(1)) begin
            state               <= OUTPUT;
            result_valid        <= 1'b1;
            inferred_type       <= best_next;
            result_min_distance <= head_distance;
            result_k            <= k_eff;
            result_samples      <= samples;
          end
        end
        OUTPUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            best         <= '0;
            best_count   <= '0;
            samples      <= '0;
            state        <= COLLECT;
            for (int i = 0; i < NT; i++) votes[i] <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
